// File: rtl/serial_mac_multiplier.sv
// Bit-serial signed/unsigned multiply-accumulate unit, one multiplier bit per cycle.
// Start/busy/valid handshake; optional accumulation into a guarded wrap-around accumulator.
module serial_mac_multiplier #(
    parameter int WIDTH = 12,
    parameter int GUARD = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic                       a_signed,
    input  logic                       b_signed,
    input  logic                       acc_mode,
    input  logic                       acc_clr,
    output logic                       busy,
    output logic                       valid,
    output logic [2*WIDTH-1:0]         prod,
    output logic [2*WIDTH+GUARD-1:0]   acc
);

    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic              r_aSigned;
    logic              r_bSigned;
    logic              r_accMode;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_sum;
    logic [PW-1:0]     r_prod;
    logic [AW-1:0]     r_acc;
    logic              r_valid;

    logic              w_accept;
    logic              w_last;
    logic [PW-1:0]     w_aExt;
    logic [PW-1:0]     w_addend;
    logic [PW-1:0]     w_step;
    logic [AW-1:0]     w_prodExt;
    logic [AW-1:0]     w_accBase;

    // DONE also accepts a start so back-to-back operations run every WIDTH+1 cycles.
    assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last    = (r_state == CALC) && (r_cnt == CW'(WIDTH - 1));

    assign w_aExt    = r_aSigned ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
    assign w_addend  = r_b[WIDTH-1] ? w_aExt : '0;
    // Multiplier bits are consumed MSB first, so the signed MSB weight is the first step.
    assign w_step    = ((r_cnt == '0) && r_bSigned) ? ((r_sum << 1) - w_addend)
                                                     : ((r_sum << 1) + w_addend);
    assign w_prodExt = (r_aSigned || r_bSigned) ? {{GUARD{r_sum[PW-1]}}, r_sum}
                                                 : {{GUARD{1'b0}}, r_sum};
    assign w_accBase = acc_clr ? '0 : r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? CALC : IDLE;
            CALC:    w_next = w_last ? DONE : CALC;
            DONE:    w_next = start ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_aSigned <= 1'b0;
            r_bSigned <= 1'b0;
            r_accMode <= 1'b0;
            r_cnt     <= '0;
            r_sum     <= '0;
            r_prod    <= '0;
            r_acc     <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_a       <= a;
                r_b       <= b;
                r_aSigned <= a_signed;
                r_bSigned <= b_signed;
                r_accMode <= acc_mode;
                r_cnt     <= '0;
                r_sum     <= '0;
            end else if (r_state == CALC) begin
                r_sum <= w_step;
                r_b   <= {r_b[WIDTH-2:0], 1'b0};
                r_cnt <= w_last ? '0 : r_cnt + CW'(1);
            end

            // Completion reads the pre-accept flags, so an overlapping start is harmless.
            if (r_state == DONE) begin
                r_prod  <= r_sum;
                r_valid <= 1'b1;
                if (r_accMode) begin
                    r_acc <= w_accBase + w_prodExt;
                end else if (acc_clr) begin
                    r_acc <= '0;
                end
            end else if (acc_clr) begin
                r_acc <= '0;
            end
        end
    end

    assign valid = r_valid;
    assign prod  = r_prod;
    assign acc   = r_acc;

endmodule

// File: tb/tb_serial_mac_multiplier.sv
// Scoreboard bench for serial_mac_multiplier: directed vectors plus a randomised run,
// expectations queued at issue time and checked by an independent valid monitor.
module tb_serial_mac_multiplier;

    localparam int W  = 12;
    localparam int G  = 8;
    localparam int PW = 2 * W;
    localparam int AW = PW + G;

    typedef struct {
        logic [PW-1:0] prod;
        logic [AW-1:0] acc;
        int            validCyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          aSigned;
    logic          bSigned;
    logic          accMode;
    logic          accClr;
    logic          busy;
    logic          valid;
    logic [PW-1:0] prod;
    logic [AW-1:0] acc;

    exp_t          sbQ[$];
    logic [AW-1:0] modelAcc = '0;
    int            cyc = 0;
    int            checks = 0;
    int            passes = 0;
    int            validCount = 0;
    int            issued = 0;

    serial_mac_multiplier #(.WIDTH(W), .GUARD(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .a_signed (aSigned),
        .b_signed (bSigned),
        .acc_mode (accMode),
        .acc_clr  (accClr),
        .busy     (busy),
        .valid    (valid),
        .prod     (prod),
        .acc      (acc)
    );

    // Free-running clock and cycle counter used for latency expectations.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Independent reference: exact integer product of the extended operands.
    function automatic longint refValue(input logic [W-1:0] x, input logic s);
        refValue = s ? longint'($signed(x)) : longint'(x);
    endfunction

    function automatic logic [PW-1:0] refProd(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic xs, input logic ys);
        longint p;
        p = refValue(x, xs) * refValue(y, ys);
        refProd = p[PW-1:0];
    endfunction

    // Monitor: every valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && valid) begin
            validCount++;
            if (sbQ.size() == 0) begin
                checks++;
                $display("[TB] FAIL unexpected_valid: got valid=1, expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("prod", 64'(prod), 64'(e.prod));
                checkOutput("acc", 64'(acc), 64'(e.acc));
                checkOutput("latency", 64'(cyc), 64'(e.validCyc));
            end
        end
    end

    task automatic pushExpect(input logic [PW-1:0] expProd, input logic xs, input logic ys,
                              input logic mode, input logic clr, input int validCyc);
        exp_t e;
        logic [AW-1:0] ext;
        ext = (xs || ys) ? {{G{expProd[PW-1]}}, expProd} : {{G{1'b0}}, expProd};
        if (mode) begin
            modelAcc = (clr ? '0 : modelAcc) + ext;
        end else if (clr) begin
            modelAcc = '0;
        end
        e.prod     = expProd;
        e.acc      = modelAcc;
        e.validCyc = validCyc;
        sbQ.push_back(e);
        issued++;
    endtask

    // Issues one start pulse; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic ias, input logic ibs, input logic imode,
                                 input logic iclr, input logic [PW-1:0] expProd);
        pushExpect(expProd, ias, ibs, imode, iclr, cyc + W + 2);
        a       = ia;
        b       = ib;
        aSigned = ias;
        bSigned = ibs;
        accMode = imode;
        accClr  = iclr;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        accClr  = 1'b0;
        a       = W'($urandom);
        b       = W'($urandom);
        aSigned = 1'($urandom);
        bSigned = 1'($urandom);
        accMode = 1'($urandom);
    endtask

    task automatic waitIdle();
        int n = 0;
        while (sbQ.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain_timeout", 64'(sbQ.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected completion before time limit");
        checks++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        int busyCycles;
        int c0;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic ras;
        logic rbs;
        logic rmode;
        logic rclr;

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        aSigned = 1'b0; bSigned = 1'b0; accMode = 1'b0; accClr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_valid", 64'(valid), 64'd0);
        checkOutput("reset_prod", 64'(prod), 64'd0);
        checkOutput("reset_acc", 64'(acc), 64'd0);

        // Most negative squared; also measure how long busy stays high.
        applyStimulus(12'h800, 12'h800, 1'b1, 1'b1, 1'b0, 1'b0, 24'h400000);
        busyCycles = 0;
        while (busy && busyCycles < 40) begin
            busyCycles++;
            @(posedge clk);
            #1;
        end
        checkOutput("busy_cycles", 64'(busyCycles), 64'(W + 1));
        waitIdle();

        applyStimulus(12'hFFF, 12'hFFF, 1'b0, 1'b0, 1'b0, 1'b0, 24'hFFE001);
        waitIdle();
        applyStimulus(12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b1, 1'b0, 24'hFFF001);
        waitIdle();
        checkOutput("acc_neg_ext", 64'(acc), 64'hFFFF_F001);

        accClr = 1'b1;
        @(posedge clk);
        #1;
        accClr = 1'b0;
        modelAcc = '0;
        checkOutput("acc_clr_pulse", 64'(acc), 64'd0);

        applyStimulus(12'd3, 12'd5, 1'b0, 1'b0, 1'b1, 1'b0, 24'd15);
        waitIdle();
        applyStimulus(12'hFF9, 12'd2, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFF2);
        waitIdle();
        applyStimulus(12'h7FF, 12'h7FF, 1'b1, 1'b1, 1'b1, 1'b0, 24'h3FF001);
        waitIdle();
        checkOutput("acc_seq3", 64'(acc), 64'h003FF002);
        applyStimulus(12'hFFF, 12'd1, 1'b1, 1'b1, 1'b1, 1'b0, 24'hFFFFFF);
        waitIdle();
        checkOutput("acc_minus1", 64'(acc), 64'h003FF001);
        applyStimulus(12'd2, 12'd3, 1'b0, 1'b0, 1'b1, 1'b1, 24'd6);
        waitIdle();
        checkOutput("acc_clr_add", 64'(acc), 64'd6);

        // A start during CALC must be ignored entirely.
        applyStimulus(12'd9, 12'd11, 1'b0, 1'b0, 1'b0, 1'b0, 24'd99);
        repeat (4) @(posedge clk);
        #1;
        a = 12'h123; b = 12'h456; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("ignored_start_valids", 64'(validCount), 64'(issued));

        // Start held high: three back-to-back ops, one every W+1 cycles.
        c0 = cyc;
        a = 12'd3; b = 12'd5; aSigned = 1'b0; bSigned = 1'b0; accMode = 1'b1; start = 1'b1;
        pushExpect(24'd15, 1'b0, 1'b0, 1'b1, 1'b0, c0 + W + 2);
        pushExpect(24'd15, 1'b0, 1'b0, 1'b1, 1'b0, c0 + 2 * W + 3);
        pushExpect(24'd15, 1'b0, 1'b0, 1'b1, 1'b0, c0 + 3 * W + 4);
        repeat (2 * W + 3) @(posedge clk);
        #1;
        start = 1'b0;
        waitIdle();
        repeat (20) @(posedge clk);
        #1;
        checkOutput("held_start_valids", 64'(validCount), 64'(issued));
        checkOutput("held_start_acc", 64'(acc), 64'd51);

        // Reset five cycles into CALC aborts without a valid.
        a = 12'd5; b = 12'd7; aSigned = 1'b0; bSigned = 1'b0; accMode = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        modelAcc = '0;
        checkOutput("abort_busy", 64'(busy), 64'd0);
        checkOutput("abort_prod", 64'(prod), 64'd0);
        checkOutput("abort_acc", 64'(acc), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        checkOutput("abort_valids", 64'(validCount), 64'(issued));
        applyStimulus(12'd6, 12'd7, 1'b0, 1'b0, 1'b1, 1'b0, 24'd42);
        waitIdle();

        for (int i = 0; i < 1000; i++) begin
            ra    = W'($urandom);
            rb    = W'($urandom);
            ras   = 1'($urandom);
            rbs   = 1'($urandom);
            rmode = 1'($urandom);
            rclr  = ($urandom_range(0, 15) == 0);
            applyStimulus(ra, rb, ras, rbs, rmode, rclr, refProd(ra, rb, ras, rbs));
            waitIdle();
        end

        repeat (20) @(posedge clk);
        #1;
        checkOutput("total_valids", 64'(validCount), 64'(issued));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
